// File: rtl/mutex_rule_scheduler.sv
// Round-robin one-hot rule scheduler for the mutual-exclusion system datapath.
// Optional starvation monitor: define SCHED_STARVE_MON_EN.
module mutex_rule_scheduler #(
    parameter int NODES          = 3,
    parameter int DEADLOCK_LIMIT = 4,
    parameter int IDX_W          = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_run,
    input  logic [NODES-1:0] io_guard,
    output logic [NODES-1:0] io_en_a,
    output logic             io_fire_valid,
    input  logic             io_fire_ready,
    output logic [IDX_W-1:0] io_grant_idx,
    output logic             io_deadlock
`ifdef SCHED_STARVE_MON_EN
    ,
    output logic [NODES-1:0] io_starve
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] grant_q;
    logic [7:0]       idle_q;
    logic             dl_q;
    logic [NODES-1:0] en_q;
    logic             valid_q;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [8:0]       idle_inc;

    assign idle_inc = {1'b0, idle_q} + 9'd1;

    // Nodes above the pointer are searched before wrapping to the low ones.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NODES; i++) begin
            if (!found && io_guard[i] && (IDX_W'(i) > rr_q)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NODES; i++) begin
            if (!found && io_guard[i] && (IDX_W'(i) <= rr_q)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= IDX_W'(NODES - 1);
            grant_q <= '0;
            idle_q  <= '0;
            dl_q    <= 1'b0;
            en_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (io_run) state_q <= S_SELECT;
                end
                S_SELECT: begin
                    if (!io_run) begin
                        state_q <= S_IDLE;
                    end else if (found) begin
                        grant_q <= win;
                        idle_q  <= '0;
                        en_q    <= NODES'(1) << win;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        if (idle_q != 8'hFF) idle_q <= idle_q + 8'd1;
                        if (idle_inc == 9'(DEADLOCK_LIMIT)) dl_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (io_fire_ready) begin
                        rr_q    <= grant_q;
                        grant_q <= '0;
                        en_q    <= '0;
                        valid_q <= 1'b0;
                        state_q <= io_run ? S_SELECT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_en_a       = en_q;
    assign io_fire_valid = valid_q;
    assign io_grant_idx  = grant_q;
    assign io_deadlock   = dl_q;

`ifdef SCHED_STARVE_MON_EN
    logic [3:0] wait_q [NODES];
    logic       fire;

    assign fire = (state_q == S_ISSUE) && io_fire_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NODES; i++) wait_q[i] <= '0;
        end else if (fire) begin
            for (int i = 0; i < NODES; i++) begin
                if ((IDX_W'(i) == grant_q) || !io_guard[i]) begin
                    wait_q[i] <= '0;
                end else if (wait_q[i] != 4'hF) begin
                    wait_q[i] <= wait_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        io_starve = '0;
        for (int i = 0; i < NODES; i++) begin
            io_starve[i] = (wait_q[i] >= 4'(NODES));
        end
    end
`endif

    a_en_onehot: assert property (
        @(posedge clock) disable iff (reset) $onehot0(io_en_a)
    );

endmodule

// File: doc/mutex_rule_scheduler.md
Name: mutex_rule_scheduler

Overview:
- Sequences rule firing for the generated mutual-exclusion `system` datapath.
- Each cycle, picks at most one enabled node rule from per-node guard bits, round-robin.
- Drives a one-hot enable vector (io_en_a format) through a valid/ready handshake.
- Sits between the guard-evaluation logic and the `system` rule-enable input. It replaces free-running random enables with a fair, deterministic schedule.

Parameters:
- NODES, 3, number of requesting nodes (width of guard and enable vectors); legal range 2..8.
- DEADLOCK_LIMIT, 4, consecutive SELECT cycles with all guards low before io_deadlock sets; 1..255.
- IDX_W, 2, grant index width; must equal ceil(log2(NODES)), minimum 1.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- io_run  input  1  scheduler enable; low parks the block in IDLE once the current issue completes.
- io_guard  input  NODES  bit i high = node i rule guard true this cycle.
- io_en_a  output  NODES  one-hot rule enable to `system`; all-zero when not issuing.
- io_fire_valid  output  1  high while io_en_a is non-zero.
- io_fire_ready  input  1  `system` accepts the firing this cycle.
- io_grant_idx  output  IDX_W  index of the currently issued node; 0 when not issuing.
- io_deadlock  output  1  sticky; set when no guard is true for DEADLOCK_LIMIT consecutive SELECT cycles.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=NODES-1 (so node 0 wins first), idle_cnt=0, io_deadlock=0.
  - io_en_a=0, io_fire_valid=0, io_grant_idx=0.
  - Reset asserted mid-ISSUE drops the enable on the next edge with no firing completed.
- States: IDLE, SELECT, ISSUE.
- IDLE:
  - Outputs zero.
  - io_run=1 -> SELECT next cycle.
- SELECT:
  - Outputs zero.
  - Search io_guard starting at (rr_ptr+1) mod NODES, wrapping upward; first set bit wins.
  - Winner found: latch grant, idle_cnt<=0, -> ISSUE.
  - No guard set: idle_cnt<=idle_cnt+1 (saturating); when idle_cnt+1 == DEADLOCK_LIMIT, io_deadlock<=1; stay in SELECT.
  - io_run=0 in SELECT -> IDLE, with no grant taken that cycle.
- ISSUE:
  - io_en_a=1<<grant, io_fire_valid=1, io_grant_idx=grant.
  - Outputs are stable until handshake; guard deassertion during ISSUE does not retract or change the grant.
  - io_fire_ready=1: firing completes that cycle; rr_ptr<=grant; next state SELECT if io_run=1, else IDLE.
  - Minimum latency SELECT->accepted is 2 cycles, so at most one firing per 2 cycles.
- Round-robin wrap: rr_ptr=NODES-1 searches from 0. The granted node has lowest priority on the next search. A lone requester is granted repeatedly.
- io_deadlock is cleared only by reset; scheduling continues normally after it sets.
- io_fire_ready while not ISSUE is ignored.
- io_en_a is never more than one-hot; this is a required assertion.

Optional Feature:
- Macro: SCHED_STARVE_MON_EN.
- Defined:
  - Adds per-node 4-bit wait counters and output io_starve [NODES].
  - A counter increments (saturating at 15) on each accepted firing where that node's guard was high but it was not granted.
  - The counter clears when that node is granted or its guard is low at an accepted firing.
  - io_starve[i]=1 when counter i >= NODES. This is a fairness violation flag, unreachable under correct round-robin.
  - Counters reset to 0.
- Not defined: no counters, no io_starve port; all other behaviour identical.

Test Plan:
- Reset then io_run=1, io_guard=3'b111, io_fire_ready=1 -> io_en_a sequence 001,010,100,001 on issue cycles 2,4,6,8; io_grant_idx 0,1,2,0.
- io_guard=3'b100 only, ready=1 -> io_en_a=100 repeatedly; io_grant_idx=2 each issue; no wrap to 0/1.
- io_guard=3'b010, ready held 0 for 5 cycles, guard dropped to 0 at cycle 3 -> io_en_a stays 010 and valid stays 1 until ready; then SELECT.
- io_run=1, io_guard=0 for 4 SELECT cycles (DEADLOCK_LIMIT=4) -> io_deadlock=1 on 5th edge; later guard=001 -> grant proceeds, io_deadlock stays 1 until reset.
- Reset asserted during ISSUE with io_en_a=010 -> next cycle io_en_a=000, valid=0, state IDLE; after release with guard=111, first grant is node 0.
- With SCHED_STARVE_MON_EN, guard=111, ready=1 over 30 firings -> io_starve stays 000 throughout.
